// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of a single-cycle ALU between two requesters.
// One operation at a time: accept (IDLE), execute (EXEC), return result (RESP).
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_in1,
  input  logic [DATA_W-1:0] req0_in2,
  input  logic [4:0]        req0_shamt,
  input  logic [5:0]        req0_funct,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_in1,
  input  logic [DATA_W-1:0] req1_in2,
  input  logic [4:0]        req1_shamt,
  input  logic [5:0]        req1_funct,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [4:0]        alu_shamt,
  output logic [5:0]        alu_funct,
  input  logic [DATA_W-1:0] alu_result,
  output logic              busy,
  output logic [CNT_W-1:0]  ops_done
);

  localparam logic [5:0] F_ADD = 6'b001001;
  localparam logic [5:0] F_SUB = 6'b001010;
  localparam logic [5:0] F_SLL = 6'b100001;
  localparam logic [5:0] F_OR  = 6'b100101;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_next;
  logic   last_grant;
  logic   owner;
  logic   winner;
  logic   rsp_take;
  logic   funct_ok;

  assign rsp_take = owner ? rsp1_ready : rsp0_ready;
  assign funct_ok = (alu_funct == F_ADD) || (alu_funct == F_SUB) ||
                    (alu_funct == F_SLL) || (alu_funct == F_OR);

  assign rsp0_valid = (state == RESP) && !owner;
  assign rsp1_valid = (state == RESP) && owner;
  assign busy       = (state != IDLE);

  // On a tie the requester that was not served last wins.
  always_comb begin
    winner     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    state_next = state;
    case (state)
      IDLE: begin
        if (req0_valid && req1_valid) winner = ~last_grant;
        else                          winner = req1_valid;
        req0_ready = req0_valid && !winner;
        req1_ready = req1_valid && winner;
        if (req0_valid || req1_valid) state_next = EXEC;
      end
      EXEC: state_next = RESP;
      RESP: if (rsp_take) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      alu_in1    <= '0;
      alu_in2    <= '0;
      alu_shamt  <= '0;
      alu_funct  <= '0;
      ops_done   <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            owner     <= winner;
            alu_in1   <= winner ? req1_in1   : req0_in1;
            alu_in2   <= winner ? req1_in2   : req0_in2;
            alu_shamt <= winner ? req1_shamt : req0_shamt;
            alu_funct <= winner ? req1_funct : req0_funct;
          end
        end
        EXEC: begin
          rsp_data <= alu_result;
          rsp_err  <= !funct_ok;
        end
        RESP: begin
          if (rsp_take) begin
            last_grant <= owner;
            ops_done   <= ops_done + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: directed scenarios then random traffic,
// with a behavioural ALU attached to the alu_* port group.
module tb_alu_share_arbiter;

  localparam logic [5:0] F_ADD = 6'b001001;
  localparam logic [5:0] F_SUB = 6'b001010;
  localparam logic [5:0] F_SLL = 6'b100001;
  localparam logic [5:0] F_OR  = 6'b100101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic [4:0]  req0_shamt, req1_shamt;
  logic [5:0]  req0_funct, req1_funct;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] alu_in1, alu_in2, alu_result;
  logic [4:0]  alu_shamt;
  logic [5:0]  alu_funct;
  logic        busy;
  logic [15:0] ops_done;

  alu_share_arbiter #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in1(req0_in1),
    .req0_in2(req0_in2), .req0_shamt(req0_shamt), .req0_funct(req0_funct),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in1(req1_in1),
    .req1_in2(req1_in2), .req1_shamt(req1_shamt), .req1_funct(req1_funct),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_shamt(alu_shamt),
    .alu_funct(alu_funct), .alu_result(alu_result),
    .busy(busy), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_funct)
      F_ADD:   alu_result = alu_in1 + alu_in2;
      F_SUB:   alu_result = alu_in1 - alu_in2;
      F_SLL:   alu_result = alu_in1 << alu_shamt;
      F_OR:    alu_result = alu_in1 | alu_in2;
      default: alu_result = '0;
    endcase
  end

  typedef struct {
    bit          owner;
    logic [31:0] in1, in2, res;
    logic [4:0]  sh;
    logic [5:0]  fn;
    bit          err;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          outstanding = 0;
  bit          tb_last = 1;
  logic [15:0] ops_exp = '0;
  bit          a0, a1;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [31:0] x, input logic [31:0] y,
                                          input logic [4:0] s, input logic [5:0] f);
    longint unsigned p;
    case (f)
      F_ADD:   p = longint'(x) + longint'(y);
      F_SUB:   p = longint'(x) + 64'h1_0000_0000 - longint'(y);
      F_SLL:   p = longint'(x) * (64'd1 << s);
      F_OR:    p = longint'(x | y);
      default: p = 0;
    endcase
    return p[31:0];
  endfunction

  // Monitor and scoreboard: all model state lives in this one process.
  always @(negedge clk) begin
    exp_t e;
    bit   w;
    if (!rst_n) begin
      chk("reset_ctrl", {busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready, rsp_err}, '0);
      chk("reset_ops_done", ops_done, '0);
      chk("reset_rsp_data", rsp_data, '0);
      chk("reset_alu", {alu_in1, alu_shamt, alu_funct}, '0);
      sb.delete();
      outstanding = 0;
      tb_last     = 1;
      ops_exp     = '0;
    end else begin
      chk("ops_done", ops_done, ops_exp);
      chk("busy", busy, outstanding);
      if (outstanding) begin
        e = sb[0];
        chk("ready_while_busy", {req0_ready, req1_ready}, 2'b00);
        if (cyc - e.acc == 1) begin
          chk("exec_alu_ops", {alu_in1, alu_in2}, {e.in1, e.in2});
          chk("exec_alu_ctl", {alu_shamt, alu_funct}, {e.sh, e.fn});
          chk("rsp_valid_exec", {rsp0_valid, rsp1_valid}, 2'b00);
        end else begin
          chk("rsp_valid", {rsp0_valid, rsp1_valid}, e.owner ? 2'b01 : 2'b10);
          chk("rsp_data", rsp_data, e.res);
          chk("rsp_err", rsp_err, e.err);
          if (e.owner ? rsp1_ready : rsp0_ready) begin
            void'(sb.pop_front());
            outstanding = 0;
            ops_exp     = ops_exp + 16'd1;
            tb_last     = e.owner;
          end
        end
      end else begin
        chk("rsp_valid_idle", {rsp0_valid, rsp1_valid}, 2'b00);
        if (req0_valid || req1_valid) begin
          w = (req0_valid && req1_valid) ? !tb_last : req1_valid;
          chk("grant", {req0_ready, req1_ready}, w ? 2'b01 : 2'b10);
          e.owner = w;
          e.in1   = w ? req1_in1   : req0_in1;
          e.in2   = w ? req1_in2   : req0_in2;
          e.sh    = w ? req1_shamt : req0_shamt;
          e.fn    = w ? req1_funct : req0_funct;
          e.res   = ref_res(e.in1, e.in2, e.sh, e.fn);
          e.err   = !(e.fn inside {F_ADD, F_SUB, F_SLL, F_OR});
          e.acc   = cyc;
          sb.push_back(e);
          outstanding = 1;
        end else begin
          chk("ready_no_valid", {req0_ready, req1_ready}, 2'b00);
        end
      end
    end
  end

  task automatic set_req(input bit r, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] s, input logic [5:0] f);
    if (r) begin
      req1_valid = 1; req1_in1 = x; req1_in2 = y; req1_shamt = s; req1_funct = f;
    end else begin
      req0_valid = 1; req0_in1 = x; req0_in2 = y; req0_shamt = s; req0_funct = f;
    end
  endtask

  task automatic tick(input bit hold);
    @(negedge clk);
    a0 = req0_valid && req0_ready;
    a1 = req1_valid && req1_ready;
    @(posedge clk);
    #1;
    if (!hold && a0) req0_valid = 0;
    if (!hold && a1) req1_valid = 0;
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max; i++) begin
      if (!req0_valid && !req1_valid && !outstanding) return;
      tick(0);
    end
    n_checks++;
    n_fail++;
    $display("FAIL drain_timeout: got busy expected idle within %0d cycles", max);
  endtask

  task automatic do_reset();
    #1;
    rst_n = 0;
    req0_valid = 0;
    req1_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic rand_req(input bit r);
    logic [5:0] f;
    case ($urandom_range(0, 4))
      0: f = F_ADD;
      1: f = F_SUB;
      2: f = F_SLL;
      3: f = F_OR;
      default: f = 6'($urandom_range(0, 63));
    endcase
    set_req(r, $urandom, $urandom, 5'($urandom_range(0, 31)), f);
  endtask

  initial begin
    int g;
    rst_n = 0;
    req0_valid = 0; req1_valid = 0;
    req0_in1 = '0; req0_in2 = '0; req0_shamt = '0; req0_funct = '0;
    req1_in1 = '0; req1_in2 = '0; req1_shamt = '0; req1_funct = '0;
    rsp0_ready = 1; rsp1_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;

    set_req(0, 5, 3, 0, F_ADD);
    drain(20);

    do_reset();
    set_req(0, 10, 4, 0, F_SUB);
    set_req(1, 32'hF0, 32'h0F, 0, F_OR);
    g = 0;
    for (int i = 0; i < 40 && g < 4; i++) begin
      tick(1);
      g += int'(a0) + int'(a1);
    end
    req0_valid = 0;
    req1_valid = 0;
    drain(20);

    set_req(0, 0, 1, 0, F_SUB);
    drain(20);
    set_req(1, 1, 0, 31, F_SLL);
    drain(20);

    rsp1_ready = 0;
    set_req(1, 32'h1234, 32'h4321, 0, F_ADD);
    for (int i = 0; i < 10 && req1_valid; i++) tick(0);
    set_req(0, 32'hA, 32'h5, 0, F_OR);
    repeat (7) tick(0);
    rsp1_ready = 1;
    drain(20);

    set_req(0, 7, 9, 0, 6'b000000);
    drain(20);
    set_req(1, 32'hFFFF_FFFF, 2, 0, F_ADD);
    drain(20);

    set_req(0, 100, 1, 0, F_ADD);
    for (int i = 0; i < 10 && req0_valid; i++) tick(0);
    do_reset();
    set_req(0, 3, 4, 0, F_ADD);
    set_req(1, 5, 6, 0, F_ADD);
    for (int i = 0; i < 10 && req0_valid && req1_valid; i++) tick(0);
    req0_valid = 0;
    req1_valid = 0;
    drain(20);

    for (int i = 0; i < 3000; i++) begin
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
      if (!req0_valid && $urandom_range(0, 2) == 0) rand_req(0);
      else if (req0_valid && $urandom_range(0, 15) == 0) req0_valid = 0;
      if (!req1_valid && $urandom_range(0, 2) == 0) rand_req(1);
      else if (req1_valid && $urandom_range(0, 15) == 0) req1_valid = 0;
      tick(0);
    end
    req0_valid = 0;
    req1_valid = 0;
    rsp0_ready = 1;
    rsp1_ready = 1;
    drain(50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got still running expected finished by 100000 cycles");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single-cycle ALU datapath (add/sub/sll/or, selected by 6-bit Funct) between two requesters, e.g. the execute stage and a multi-cycle helper unit.
- Arbitrates round-robin, registers operands into the ALU, captures the result and returns it to the winning requester over a valid/ready handshake.
- Flags Funct codes the ALU does not support.

Parameters:
- DATA_W, 32, operand/result width; must match the ALU (32).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_in1 / req0_in2  in  DATA_W each  requester 0 operands.
- req0_shamt  in  5  requester 0 shift amount.
- req0_funct  in  6  requester 0 function code.
- req1_valid, req1_ready, req1_in1, req1_in2, req1_shamt, req1_funct  same as requester 0, for requester 1.
- rsp0_valid  out  1  result for requester 0 available.
- rsp0_ready  in  1  requester 0 takes its result.
- rsp1_valid  out  1  result for requester 1 available.
- rsp1_ready  in  1  requester 1 takes its result.
- rsp_data  out  DATA_W  result, shared by both responses.
- rsp_err  out  1  Funct was unsupported; qualified by rspX_valid.
- alu_in1 / alu_in2  out  DATA_W each  operands to the ALU.
- alu_shamt  out  5  shift amount to the ALU.
- alu_funct  out  6  function code to the ALU.
- alu_result  in  DATA_W  combinational ALU result.
- busy  out  1  high whenever state != IDLE.
- ops_done  out  CNT_W  count of completed response handshakes.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, last_grant=1 (requester 0 wins the first tie).
  - All req*_ready, rsp*_valid, rsp_err and busy are 0.
  - rsp_data, alu_* and ops_done are 0.
- States: IDLE, EXEC, RESP. Minimum 3 cycles per operation. No pipelining.
- IDLE:
  - Winner: if only one reqX_valid, that one. If both, the index != last_grant.
  - reqX_ready is asserted combinationally, only for the winner, only in IDLE. The loser's ready stays 0.
  - On valid&&ready: latch in1/in2/shamt/funct into operand regs, record owner, go to EXEC.
  - With no valid, stay in IDLE. alu_* hold their last values.
- EXEC (one cycle):
  - alu_* are driven from the operand regs (registered outputs, stable all cycle).
  - At the clock edge, capture alu_result into rsp_data.
  - rsp_err = funct not in {001001, 001010, 100001, 100101}. For an unsupported funct, rsp_data=0 (from the ALU default).
  - Go to RESP.
- RESP:
  - rsp<owner>_valid=1. The other rsp valid is 0.
  - rsp_data and rsp_err are held stable until rsp<owner>_ready=1.
  - On the handshake: last_grant=owner, ops_done+=1 (wraps at 2^CNT_W-1 -> 0), go to IDLE.
  - No new request is accepted in the handshake cycle.
- Requester protocol:
  - reqX_valid and its operands must stay stable until ready.
  - Dropping valid before ready is legal and has no effect.
  - Operand changes while no handshake is occurring are ignored.
- Arithmetic: performed entirely by the ALU. add/sub wrap modulo 2^32. The block never modifies the data.
- Simultaneous events:
  - A new reqX_valid during EXEC/RESP waits.
  - A requester holding valid through RESP is granted in the following IDLE cycle per round-robin.
- Reset mid-operation (EXEC or RESP): the operation is dropped, no response is issued, outputs return to reset values immediately.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1...

Test Plan:
- Single op: req0 add (funct 001001), in1=5, in2=3. Required: req0_ready in cycle 0, rsp0_valid in cycle 2 with rsp_data=8, rsp_err=0, ops_done=1 after the handshake.
- Tie and fairness: both valid from reset, req0 sub 10-4, req1 or 0xF0|0x0F, both held. Required: grant order 0,1,0,1; results 6 and 0xFF alternate; req1_ready is never high while req0_ready is high.
- Wrap and shift: sub in1=0, in2=1 -> rsp_data=0xFFFFFFFF. sll in1=1, shamt=31 -> 0x80000000. alu_shamt=31 during EXEC.
- Backpressure: rsp1_ready held 0 for 5 cycles after rsp1_valid. Required: rsp_data and rsp_err stable, busy=1, req0 not granted until the cycle after the rsp1 handshake.
- Illegal funct 000000 with in1=7, in2=9 -> rsp_err=1, rsp_data=0. A following legal op gives rsp_err=0.
- Reset mid-op: assert rst_n=0 during EXEC. Required: rsp*_valid never asserts, busy=0 immediately, ops_done=0. After release, req0 wins a tie.
